// File: rtl/wind_lights.sv
// Lane/wind indicator pattern generator for N lamps with a built-in step prescaler.
// Optional macro WIND_LIGHTS_BOUNCE_EN turns mode 11 into a bounce pattern; otherwise mode 11 shows calm.
module wind_lights #(
  parameter int N   = 3,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   in,
  output logic [N-1:0] out,
  output logic         step,
  output logic [1:0]   mode_q
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [N-1:0] LSB_ONLY = N'(1);
  localparam logic [N-1:0] MSB_ONLY = N'(1) << (N - 1);
  localparam logic [N-1:0] OUTER    = MSB_ONLY | LSB_ONLY;
  localparam logic [N-1:0] CENTER   = (N % 2 == 1) ? (N'(1) << ((N - 1) / 2))
                                                    : (N'(3) << (N / 2 - 1));

  typedef enum logic [1:0] {
    M_CALM = 2'b00,
    M_UP   = 2'b01,
    M_DOWN = 2'b10,
    M_ALT  = 2'b11
  } mode_e;

  mode_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     out_q, out_d;

  function automatic logic [N-1:0] init_pattern(input logic [1:0] m);
    case (m)
      2'b01:   init_pattern = LSB_ONLY;
      2'b10:   init_pattern = MSB_ONLY;
`ifdef WIND_LIGHTS_BOUNCE_EN
      2'b11:   init_pattern = LSB_ONLY;
`endif
      default: init_pattern = OUTER;
    endcase
  endfunction

  // The whole design advances only on the prescaler wrap cycle; reset masks it.
  always_comb begin
    step  = !reset && (cnt_q == CNT_MAX);
    cnt_d = step ? '0 : cnt_q + 1'b1;
  end

`ifdef WIND_LIGHTS_BOUNCE_EN
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  logic dir_q, dir_d;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef WIND_LIGHTS_BOUNCE_EN
    dir_d   = dir_q;
`endif
    if (step) begin
      if (mode_e'(in) != state_q) begin
        state_d = mode_e'(in);
        out_d   = init_pattern(in);
`ifdef WIND_LIGHTS_BOUNCE_EN
        dir_d   = DIR_UP;
`endif
      end else begin
        case (state_q)
          M_UP:   out_d = {out_q[N-2:0], out_q[N-1]};
          M_DOWN: out_d = {out_q[0], out_q[N-1:1]};
`ifdef WIND_LIGHTS_BOUNCE_EN
          M_ALT: begin
            // Turn around on reaching an end lamp so the end lamps are not repeated.
            if (dir_q == DIR_UP) begin
              if (out_q[N-1]) begin
                out_d = out_q >> 1;
                dir_d = DIR_DN;
              end else begin
                out_d = out_q << 1;
              end
            end else begin
              if (out_q[0]) begin
                out_d = out_q << 1;
                dir_d = DIR_UP;
              end else begin
                out_d = out_q >> 1;
              end
            end
          end
`endif
          default: out_d = (out_q == OUTER) ? CENTER : OUTER;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= M_CALM;
      out_q   <= OUTER;
`ifdef WIND_LIGHTS_BOUNCE_EN
      dir_q   <= DIR_UP;
`endif
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      out_q   <= out_d;
`ifdef WIND_LIGHTS_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign out    = out_q;
  assign mode_q = state_q;

endmodule

// File: tb/tb_wind_lights.sv
// Bench for wind_lights: four instances (N/DIV = 3/1, 4/4, 5/1, 3/3) against a step-index model.
// Honours WIND_LIGHTS_BOUNCE_EN the same way as the design.
module tb_wind_lights;

  localparam int N_TAB   [4] = '{3, 4, 5, 3};
  localparam int DIV_TAB [4] = '{1, 4, 1, 3};

  logic        clk;
  logic        rst    [4];
  logic [1:0]  in_v   [4];
  logic        a_step [4];
  logic [1:0]  a_mode [4];
  logic [15:0] a_out  [4];
  logic [2:0]  o0;
  logic [3:0]  o1;
  logic [4:0]  o2;
  logic [2:0]  o3;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  // Model state: prescale count, displayed mode, steps taken since the mode was loaded.
  int       m_cnt  [4];
  logic [1:0] m_mode [4];
  int       m_k    [4];

  logic [4:0] seq5 [10];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  wind_lights #(.N(3), .DIV(1)) u0 (.clk(clk), .reset(rst[0]), .in(in_v[0]), .out(o0), .step(a_step[0]), .mode_q(a_mode[0]));
  wind_lights #(.N(4), .DIV(4)) u1 (.clk(clk), .reset(rst[1]), .in(in_v[1]), .out(o1), .step(a_step[1]), .mode_q(a_mode[1]));
  wind_lights #(.N(5), .DIV(1)) u2 (.clk(clk), .reset(rst[2]), .in(in_v[2]), .out(o2), .step(a_step[2]), .mode_q(a_mode[2]));
  wind_lights #(.N(3), .DIV(3)) u3 (.clk(clk), .reset(rst[3]), .in(in_v[3]), .out(o3), .step(a_step[3]), .mode_q(a_mode[3]));

  assign a_out[0] = {13'd0, o0};
  assign a_out[1] = {12'd0, o1};
  assign a_out[2] = {11'd0, o2};
  assign a_out[3] = {13'd0, o3};

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pattern after k steps in mode m, derived from the pattern rules.
  function automatic logic [15:0] exp_out(input int n, input logic [1:0] m, input int k);
    logic [15:0] outer, center;
    int p;
    outer  = (16'd1 << (n - 1)) | 16'd1;
    center = (n % 2 == 1) ? (16'd1 << ((n - 1) / 2)) : (16'd3 << (n / 2 - 1));
    case (m)
      2'b01: return 16'd1 << (k % n);
      2'b10: return 16'd1 << (n - 1 - (k % n));
`ifdef WIND_LIGHTS_BOUNCE_EN
      2'b11: begin
        p = k % (2 * n - 2);
        return 16'd1 << ((p < n) ? p : (2 * n - 2 - p));
      end
`endif
      default: return (k % 2 == 0) ? outer : center;
    endcase
  endfunction

  // ---------------- model ----------------
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst[i]) begin
        m_cnt[i]  = 0;
        m_mode[i] = 2'b00;
        m_k[i]    = 0;
      end else if (m_cnt[i] == DIV_TAB[i] - 1) begin
        m_cnt[i] = 0;
        if (in_v[i] != m_mode[i]) begin
          m_mode[i] = in_v[i];
          m_k[i]    = 0;
        end else begin
          m_k[i] = m_k[i] + 1;
        end
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("model_out[%0d]", i), a_out[i], exp_out(N_TAB[i], m_mode[i], m_k[i]));
        check($sformatf("model_step[%0d]", i), {15'd0, a_step[i]},
              {15'd0, (!rst[i] && (m_cnt[i] == DIV_TAB[i] - 1))});
        check($sformatf("model_mode[%0d]", i), {14'd0, a_mode[i]}, {14'd0, m_mode[i]});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
`ifdef WIND_LIGHTS_BOUNCE_EN
    seq5 = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
             5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00010};
`else
    seq5 = '{5'b10001, 5'b00100, 5'b10001, 5'b00100, 5'b10001,
             5'b00100, 5'b10001, 5'b00100, 5'b10001, 5'b00100};
`endif
    for (int i = 0; i < 4; i++) begin
      rst[i]  = 1'b1;
      in_v[i] = 2'b00;
      m_cnt[i] = 0;
      m_mode[i] = 2'b00;
      m_k[i] = 0;
    end

    // Directed phase: k counts rising edges; checks precede this cycle's drives.
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) cmp_en = 1'b1;
      case (k)
        1: begin
          check("rst_out0", {13'd0, o0}, 16'h5);
          check("rst_step0", {15'd0, a_step[0]}, 16'h0);
          check("rst_mode0", {14'd0, a_mode[0]}, 16'h0);
          for (int i = 0; i < 4; i++) rst[i] = 1'b0;
          in_v[2] = 2'b11;
          in_v[3] = 2'b10;
        end
        2: begin
          check("calm_out0_a", {13'd0, o0}, 16'h2);
          check("calm_step0", {15'd0, a_step[0]}, 16'h1);
        end
        3: check("calm_out0_b", {13'd0, o0}, 16'h5);
        4: begin
          check("calm_out0_c", {13'd0, o0}, 16'h2);
          check("div4_hold1", {12'd0, o1}, 16'h9);
          check("div4_step1", {15'd0, a_step[1]}, 16'h1);
          check("div3_load3", {13'd0, o3}, 16'h4);
          check("div3_mode3", {14'd0, a_mode[3]}, 16'h2);
          in_v[0] = 2'b01;
        end
        5: begin
          check("up_load0", {13'd0, o0}, 16'h1);
          check("up_mode0", {14'd0, a_mode[0]}, 16'h1);
          check("div4_adv1", {12'd0, o1}, 16'h6);
          check("div4_nostep1", {15'd0, a_step[1]}, 16'h0);
          in_v[1] = 2'b01;
        end
        6: check("up_out0_a", {13'd0, o0}, 16'h2);
        7: begin
          check("up_out0_b", {13'd0, o0}, 16'h4);
          check("div3_rot3", {13'd0, o3}, 16'h2);
          in_v[1] = 2'b00;
        end
        8: begin
          check("up_wrap0", {13'd0, o0}, 16'h1);
          check("div3_pre_rst3", {13'd0, o3}, 16'h2);
          in_v[0] = 2'b10;
          rst[3]  = 1'b1;
        end
        9: begin
          check("dn_load0", {13'd0, o0}, 16'h4);
          check("dn_mode0", {14'd0, a_mode[0]}, 16'h2);
          check("pulse_mode1", {14'd0, a_mode[1]}, 16'h0);
          check("pulse_out1", {12'd0, o1}, 16'h9);
          check("mid_rst_out3", {13'd0, o3}, 16'h5);
          check("mid_rst_mode3", {14'd0, a_mode[3]}, 16'h0);
          rst[3] = 1'b0;
        end
        10: begin
          check("dn_out0_a", {13'd0, o0}, 16'h2);
          check("post_rst_nostep3", {15'd0, a_step[3]}, 16'h0);
        end
        11: begin
          check("dn_out0_b", {13'd0, o0}, 16'h1);
          check("post_rst_step3", {15'd0, a_step[3]}, 16'h1);
        end
        12: begin
          check("dn_wrap0", {13'd0, o0}, 16'h4);
          check("post_rst_load3", {13'd0, o3}, 16'h4);
          check("post_rst_mode3", {14'd0, a_mode[3]}, 16'h2);
        end
        default: ;
      endcase
      if (k >= 2 && k <= 11) begin
        check($sformatf("alt5_step%0d", k - 2), {11'd0, o2}, {11'd0, seq5[k-2]});
        check($sformatf("alt5_mode%0d", k - 2), {14'd0, a_mode[2]}, 16'h3);
      end
    end

    // Mixed phase: varied mode requests and occasional resets, checked by the model.
    for (int k = 13; k <= 80; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) in_v[i] = 2'($urandom_range(0, 3));
        rst[i] = ($urandom_range(0, 24) == 0);
      end
    end
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
